// File: rtl/conv_layer_2d.sv
// conv_layer_2d: valid-mode, stride-1 2-D cross-correlation of a whole frame per clock.
// Stage 1 registers every window product; stage 2 sums them in an adder tree and applies the activation.
module conv_layer_2d #(
    parameter int DATA_WIDTH  = 8,
    parameter int KDATA_WIDTH = 8,
    parameter int KERNEL_SIZE = 2,
    parameter     ACTIVATION  = "RELU",
    parameter int IMGCOL      = 3,
    parameter int IMGROW      = 7,
    localparam int OROW       = IMGROW - KERNEL_SIZE + 1,
    localparam int OCOL       = IMGCOL - KERNEL_SIZE + 1,
    localparam int OUT_WIDTH  = DATA_WIDTH + KDATA_WIDTH + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [DATA_WIDTH-1:0]  image    [0:IMGROW-1][0:IMGCOL-1],
    input  logic signed [KDATA_WIDTH-1:0] kernel   [0:KERNEL_SIZE-1][0:KERNEL_SIZE-1],
    output logic signed [OUT_WIDTH-1:0]   conv_out [0:OROW-1][0:OCOL-1]
);
    localparam int K        = KERNEL_SIZE;
    localparam int NTAP     = K * K;
    localparam int PW       = DATA_WIDTH + KDATA_WIDTH;
    localparam int NLEAF    = 1 << $clog2(NTAP);
    localparam int NNODE    = 2 * NLEAF - 1;
    localparam bit USE_RELU = (ACTIVATION == "RELU");

    for (genvar i = 0; i < OROW; i++) begin : g_row
        for (genvar j = 0; j < OCOL; j++) begin : g_col
            logic signed [PW-1:0]        r_prod [0:NTAP-1];
            logic signed [OUT_WIDTH-1:0] w_tree [0:NNODE-1];
            logic signed [OUT_WIDTH-1:0] w_acc;
            logic signed [OUT_WIDTH-1:0] r_out;

            always_ff @(posedge clk) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K; c++) begin
                        if (rst) begin
                            r_prod[r*K+c] <= '0;
                        end else begin
                            r_prod[r*K+c] <= PW'(image[i+r][j+c]) * PW'(kernel[r][c]);
                        end
                    end
                end
            end

            // Heap-ordered tree: leaves sit at NLEAF-1.., unused leaves stay zero.
            always_comb begin
                w_tree = '{default: '0};
                for (int n = 0; n < NTAP; n++) begin
                    w_tree[NLEAF-1+n] = OUT_WIDTH'(r_prod[n]);
                end
                for (int n = NLEAF - 2; n >= 0; n--) begin
                    w_tree[n] = w_tree[2*n+1] + w_tree[2*n+2];
                end
                w_acc = w_tree[0];
            end

            always_ff @(posedge clk) begin
                if (rst || (USE_RELU && w_acc[OUT_WIDTH-1])) begin
                    r_out <= '0;
                end else begin
                    r_out <= w_acc;
                end
            end

            assign conv_out[i][j] = r_out;
        end
    end
endmodule

// File: tb/tb_conv_layer_2d.sv
// Scoreboard bench for conv_layer_2d: RELU, NONE, K=1 and K=3 instances share one image stream;
// expected frames are queued when issued and checked by an independent monitor two clocks later.
module tb_conv_layer_2d;
    localparam int NSTEP = 18;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic signed [7:0]  image   [0:6][0:2];
    logic signed [7:0]  kern2   [0:1][0:1];
    logic signed [7:0]  kern1   [0:0][0:0];
    logic signed [7:0]  kern3   [0:2][0:2];
    logic signed [17:0] outRelu [0:5][0:1];
    logic signed [17:0] outNone [0:5][0:1];
    logic signed [15:0] outK1   [0:6][0:2];
    logic signed [19:0] outK3   [0:4][0:0];

    conv_layer_2d #(.ACTIVATION("RELU")) uRelu (
        .clk(clk), .rst(rst), .image(image), .kernel(kern2), .conv_out(outRelu));
    conv_layer_2d #(.ACTIVATION("NONE")) uNone (
        .clk(clk), .rst(rst), .image(image), .kernel(kern2), .conv_out(outNone));
    conv_layer_2d #(.KERNEL_SIZE(1), .ACTIVATION("NONE")) uK1 (
        .clk(clk), .rst(rst), .image(image), .kernel(kern1), .conv_out(outK1));
    conv_layer_2d #(.KERNEL_SIZE(3), .ACTIVATION("NONE")) uK3 (
        .clk(clk), .rst(rst), .image(image), .kernel(kern3), .conv_out(outK3));

    int nomImg [0:6][0:2] = '{'{-2, 4, -1}, '{4, 1, -1}, '{1, 6, -1}, '{2, 4, -1},
                              '{6, 2, -1}, '{6, 1, -1}, '{1, 2, -1}};
    int nomK2 [0:1][0:1] = '{'{2, -14}, '{-4, -2}};
    int nomK3 [0:2][0:2] = '{'{1, -2, 3}, '{-1, 0, 2}, '{2, 1, -3}};
    int expNone2 [0:5][0:1] = '{'{-78, 20}, '{-22, -6}, '{-98, 12}, '{-80, 16}, '{-42, 16}, '{-10, 10}};
    int expRelu2 [0:5][0:1] = '{'{0, 20}, '{0, 0}, '{0, 12}, '{0, 16}, '{0, 16}, '{0, 10}};
    int expK1 [0:6][0:2] = '{'{-6, 12, -3}, '{12, 3, -3}, '{3, 18, -3}, '{6, 12, -3},
                             '{18, 6, -3}, '{18, 3, -3}, '{3, 6, -3}};

    // Image select: 0 nominal, 1 all -128, 2 all zero. Kernel select: 0 nominal, 1 all -128, 2 all 127, 3 zero.
    bit stepRst [0:NSTEP-1] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    int stepImg [0:NSTEP-1] = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1, 0, 1};
    int stepKer [0:NSTEP-1] = '{0, 0, 0, 0, 1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2};

    int sbQ[$];
    int total = 0;
    int bad = 0;
    bit issueValid = 1'b0;
    bit p1V = 1'b0;
    bit p2V = 1'b0;

    always @(posedge clk) begin
        p1V <= issueValid;
        p2V <= p1V;
    end

    function automatic int pixel(input int sel, input int r, input int c);
        if (sel == 0) return nomImg[r][c];
        if (sel == 1) return -128;
        return 0;
    endfunction

    function automatic int weightOf(input int k, input int sel, input int r, input int c);
        if (sel == 1) return -128;
        if (sel == 2) return 127;
        if (sel == 3) return 0;
        if (k == 1) return 3;
        if (k == 2) return nomK2[r][c];
        return nomK3[r][c];
    endfunction

    function automatic int expectK2(input bit relu, input int img, input int ker, input int i, input int j);
        if (img == 0 && ker == 0) return relu ? expRelu2[i][j] : expNone2[i][j];
        if (img == 1 && ker == 1) return 65536;
        if (img == 1 && ker == 2) return relu ? 0 : -65024;
        return 0;
    endfunction

    function automatic int expectK1(input int img, input int ker, input int i, input int j);
        if (img == 0 && ker == 0) return expK1[i][j];
        if (img == 1 && ker == 1) return 16384;
        if (img == 1 && ker == 2) return -16256;
        return 0;
    endfunction

    function automatic int refK3(input int img, input int ker, input int i, input int j);
        int acc = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                acc += pixel(img, i + r, j + c) * weightOf(3, ker, r, c);
            end
        end
        return acc;
    endfunction

    task automatic applyStimulus(input bit rstVal, input int img, input int ker, input bit zero);
        @(negedge clk);
        rst = rstVal;
        for (int rr = 0; rr < 7; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                image[rr][cc] = 8'(pixel(img, rr, cc));
            end
        end
        for (int rr = 0; rr < 2; rr++) begin
            for (int cc = 0; cc < 2; cc++) begin
                kern2[rr][cc] = 8'(weightOf(2, ker, rr, cc));
            end
        end
        kern1[0][0] = 8'(weightOf(1, ker, 0, 0));
        for (int rr = 0; rr < 3; rr++) begin
            for (int cc = 0; cc < 3; cc++) begin
                kern3[rr][cc] = 8'(weightOf(3, ker, rr, cc));
            end
        end
        sbQ.push_back((zero ? 100 : 0) + img * 10 + ker);
        issueValid = 1'b1;
    endtask

    task automatic report(input string name, input bit ok, input int tag, input int i, input int j,
                          input int act, input int exp);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL %s tag=%0d out[%0d][%0d] got=%0d expected=%0d", name, tag, i, j, act, exp);
        end
    endtask

    task automatic checkOutput(input int tag);
        bit zero;
        bit ok;
        int img, ker, e, bi, bj, ba, be;
        zero = (tag / 100) != 0;
        img  = (tag / 10) % 10;
        ker  = tag % 10;

        ok = 1'b1; bi = 0; bj = 0; ba = 0; be = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 2; j++) begin
                e = zero ? 0 : expectK2(1'b1, img, ker, i, j);
                if (ok && outRelu[i][j] !== 18'(e)) begin
                    ok = 1'b0; bi = i; bj = j; ba = int'(outRelu[i][j]); be = e;
                end
            end
        end
        report("relu", ok, tag, bi, bj, ba, be);

        ok = 1'b1; bi = 0; bj = 0; ba = 0; be = 0;
        for (int i = 0; i < 6; i++) begin
            for (int j = 0; j < 2; j++) begin
                e = zero ? 0 : expectK2(1'b0, img, ker, i, j);
                if (ok && outNone[i][j] !== 18'(e)) begin
                    ok = 1'b0; bi = i; bj = j; ba = int'(outNone[i][j]); be = e;
                end
            end
        end
        report("none", ok, tag, bi, bj, ba, be);

        ok = 1'b1; bi = 0; bj = 0; ba = 0; be = 0;
        for (int i = 0; i < 7; i++) begin
            for (int j = 0; j < 3; j++) begin
                e = zero ? 0 : expectK1(img, ker, i, j);
                if (ok && outK1[i][j] !== 16'(e)) begin
                    ok = 1'b0; bi = i; bj = j; ba = int'(outK1[i][j]); be = e;
                end
            end
        end
        report("k1", ok, tag, bi, bj, ba, be);

        ok = 1'b1; bi = 0; bj = 0; ba = 0; be = 0;
        for (int i = 0; i < 5; i++) begin
            e = zero ? 0 : refK3(img, ker, i, 0);
            if (ok && outK3[i][0] !== 20'(e)) begin
                ok = 1'b0; bi = i; bj = 0; ba = int'(outK3[i][0]); be = e;
            end
        end
        report("k3", ok, tag, bi, bj, ba, be);
    endtask

    // Monitor: each issued frame surfaces two edges later and is compared against the queue head.
    initial begin
        forever begin
            @(negedge clk);
            if (p2V) begin
                if (sbQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboard underflow got=empty expected=entry");
                end else begin
                    checkOutput(sbQ.pop_front());
                end
            end
        end
    end

    initial begin
        bit nextRst;
        for (int s = 0; s < NSTEP; s++) begin
            nextRst = (s + 1 < NSTEP) ? stepRst[s+1] : 1'b0;
            applyStimulus(stepRst[s], stepImg[s], stepKer[s], stepRst[s] || nextRst);
        end
        @(negedge clk);
        issueValid = 1'b0;
        for (int w = 0; w < 10 && sbQ.size() != 0; w++) @(negedge clk);
        if (sbQ.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain pending=%0d expected=0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
